// File: rtl/tlk2711_reg_pkg.sv
// rtl/tlk2711_reg_pkg.sv - shared types, widths and helpers for the TLK2711 register arbiter
package tlk2711_reg_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int CNT_WIDTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        KIND_WR = 1'b0,
        KIND_RD = 1'b1
    } slot_kind_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        return (en && (v != {CNT_WIDTH{1'b1}})) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/tlk2711_reg_slot.sv
// rtl/tlk2711_reg_slot.sv - one requester's single-entry write slot and read slot with overflow pulse
module tlk2711_reg_slot
    import tlk2711_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_ren,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic                  i_wr_issue,
    input  logic                  i_rd_issue,
    output logic                  o_wr_full,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_rd_full,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic                  o_ovf
);

    logic                  wr_full_q, wr_full_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_full_q, rd_full_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        wr_full_d = wr_full_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        rd_full_d = rd_full_q;
        raddr_d   = raddr_q;
        if (i_wr_issue) wr_full_d = 1'b0;
        if (i_rd_issue) rd_full_d = 1'b0;
        // A slot being issued this cycle can take the new request immediately.
        if (i_wen && (!wr_full_q || i_wr_issue)) begin
            wr_full_d = 1'b1;
            waddr_d   = i_waddr;
            wdata_d   = i_wdata;
        end
        if (i_ren && (!rd_full_q || i_rd_issue)) begin
            rd_full_d = 1'b1;
            raddr_d   = i_raddr;
        end
        ovf_d = (i_wen && wr_full_q && !i_wr_issue) || (i_ren && rd_full_q && !i_rd_issue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_full_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rd_full_q <= 1'b0;
            raddr_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_full_q <= wr_full_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            rd_full_q <= rd_full_d;
            raddr_q   <= raddr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_wr_full = wr_full_q;
    assign o_waddr   = waddr_q;
    assign o_wdata   = wdata_q;
    assign o_rd_full = rd_full_q;
    assign o_raddr   = raddr_q;
    assign o_ovf     = ovf_q;

endmodule

// File: rtl/tlk2711_reg_arb.sv
// rtl/tlk2711_reg_arb.sv - two-requester round-robin register arbiter for tlk2711_top
// Optional drop counters: define TLK2711_REG_ARB_STATS_EN.
module tlk2711_reg_arb
    import tlk2711_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_m0_wen,
    input  logic [ADDR_WIDTH-1:0] i_m0_waddr,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    input  logic                  i_m0_ren,
    input  logic [ADDR_WIDTH-1:0] i_m0_raddr,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    output logic                  o_m0_rvalid,
    output logic                  o_m0_ovf,
    input  logic                  i_m1_wen,
    input  logic [ADDR_WIDTH-1:0] i_m1_waddr,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    input  logic                  i_m1_ren,
    input  logic [ADDR_WIDTH-1:0] i_m1_raddr,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    output logic                  o_m1_rvalid,
    output logic                  o_m1_ovf,
    output logic                  o_reg_wen,
    output logic [ADDR_WIDTH-1:0] o_reg_waddr,
    output logic [DATA_WIDTH-1:0] o_reg_wdata,
    output logic                  o_reg_ren,
    output logic [ADDR_WIDTH-1:0] o_reg_raddr,
    input  logic [DATA_WIDTH-1:0] i_reg_rdata,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_m0_drop_cnt,
    output logic [CNT_WIDTH-1:0]  o_m1_drop_cnt
);

    logic [1:0]            wr_full, rd_full, wr_issue, rd_issue, ovf, pend;
    logic [ADDR_WIDTH-1:0] waddr [2];
    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    tlk2711_reg_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot_m0 (
        .clk(clk), .rst(rst), .i_wen(i_m0_wen), .i_waddr(i_m0_waddr), .i_wdata(i_m0_wdata),
        .i_ren(i_m0_ren), .i_raddr(i_m0_raddr), .i_wr_issue(wr_issue[0]), .i_rd_issue(rd_issue[0]),
        .o_wr_full(wr_full[0]), .o_waddr(waddr[0]), .o_wdata(wdata[0]),
        .o_rd_full(rd_full[0]), .o_raddr(raddr[0]), .o_ovf(ovf[0])
    );

    tlk2711_reg_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot_m1 (
        .clk(clk), .rst(rst), .i_wen(i_m1_wen), .i_waddr(i_m1_waddr), .i_wdata(i_m1_wdata),
        .i_ren(i_m1_ren), .i_raddr(i_m1_raddr), .i_wr_issue(wr_issue[1]), .i_rd_issue(rd_issue[1]),
        .o_wr_full(wr_full[1]), .o_waddr(waddr[1]), .o_wdata(wdata[1]),
        .o_rd_full(rd_full[1]), .o_raddr(raddr[1]), .o_ovf(ovf[1])
    );

    arb_state_e            state_q, state_d;
    slot_kind_e            kind_q, kind_d, sel_kind;
    logic                  gnt_q, gnt_d, last_q, last_d, sel;
    logic [2:0]            lat_q, lat_d;
    logic                  reg_wen_q, reg_wen_d, reg_ren_q, reg_ren_d;
    logic [ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d, reg_raddr_q, reg_raddr_d;
    logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [DATA_WIDTH-1:0] rdata_d [2];
    logic [1:0]            rvalid_q, rvalid_d;

    // The pointer only advances on contended grants, so fairness is decided between competing requesters.
    assign pend     = wr_full | rd_full;
    assign sel      = (pend == 2'b11) ? ~last_q : pend[1];
    assign sel_kind = wr_full[sel] ? KIND_WR : KIND_RD;

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        lat_d       = lat_q;
        reg_wen_d   = 1'b0;
        reg_ren_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        reg_raddr_d = reg_raddr_q;
        rdata_d[0]  = rdata_q[0];
        rdata_d[1]  = rdata_q[1];
        rvalid_d    = 2'b00;
        wr_issue    = 2'b00;
        rd_issue    = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    state_d = ST_ISSUE;
                    gnt_d   = sel;
                    kind_d  = sel_kind;
                    if (&pend) last_d = sel;
                    if (sel_kind == KIND_WR) begin
                        reg_wen_d   = 1'b1;
                        reg_waddr_d = waddr[sel];
                        reg_wdata_d = wdata[sel];
                    end else begin
                        reg_ren_d   = 1'b1;
                        reg_raddr_d = raddr[sel];
                    end
                end
            end
            ST_ISSUE: begin
                if (kind_q == KIND_WR) begin
                    wr_issue[gnt_q] = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    rd_issue[gnt_q] = 1'b1;
                    state_d         = ST_RD_WAIT;
                    lat_d           = 3'd1;
                end
            end
            ST_RD_WAIT: begin
                if (lat_q == 3'(RD_LAT)) begin
                    state_d         = ST_IDLE;
                    rvalid_d[gnt_q] = 1'b1;
                    rdata_d[gnt_q]  = i_reg_rdata;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_WR;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            lat_q       <= '0;
            reg_wen_q   <= 1'b0;
            reg_ren_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            reg_raddr_q <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            rvalid_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            lat_q       <= lat_d;
            reg_wen_q   <= reg_wen_d;
            reg_ren_q   <= reg_ren_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_raddr_q <= reg_raddr_d;
            rdata_q[0]  <= rdata_d[0];
            rdata_q[1]  <= rdata_d[1];
            rvalid_q    <= rvalid_d;
        end
    end

`ifdef TLK2711_REG_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] drop0_q, drop0_d, drop1_q, drop1_d;

    always_comb begin
        drop0_d = sat_inc(drop0_q, ovf[0]);
        drop1_d = sat_inc(drop1_q, ovf[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop0_q <= '0;
            drop1_q <= '0;
        end else begin
            drop0_q <= drop0_d;
            drop1_q <= drop1_d;
        end
    end

    assign o_m0_drop_cnt = drop0_q;
    assign o_m1_drop_cnt = drop1_q;
`else
    assign o_m0_drop_cnt = '0;
    assign o_m1_drop_cnt = '0;
`endif

    assign o_reg_wen   = reg_wen_q;
    assign o_reg_ren   = reg_ren_q;
    assign o_reg_waddr = reg_waddr_q;
    assign o_reg_wdata = reg_wdata_q;
    assign o_reg_raddr = reg_raddr_q;
    assign o_m0_rdata  = rdata_q[0];
    assign o_m1_rdata  = rdata_q[1];
    assign o_m0_rvalid = rvalid_q[0];
    assign o_m1_rvalid = rvalid_q[1];
    assign o_m0_ovf    = ovf[0];
    assign o_m1_ovf    = ovf[1];
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tlk2711_reg_arb.sv
// tb/tb_tlk2711_reg_arb.sv - scoreboard testbench for tlk2711_reg_arb (directed vectors)
module tb_tlk2711_reg_arb;

    localparam int AW     = 16;
    localparam int DW     = 64;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_m0_wen, i_m0_ren, i_m1_wen, i_m1_ren;
    logic [AW-1:0] i_m0_waddr, i_m0_raddr, i_m1_waddr, i_m1_raddr;
    logic [DW-1:0] i_m0_wdata, i_m1_wdata;
    logic [DW-1:0] o_m0_rdata, o_m1_rdata, o_reg_wdata;
    logic          o_m0_rvalid, o_m1_rvalid, o_m0_ovf, o_m1_ovf;
    logic          o_reg_wen, o_reg_ren, o_busy;
    logic [AW-1:0] o_reg_waddr, o_reg_raddr;
    logic [DW-1:0] i_reg_rdata = '0;
    logic [15:0]   o_m0_drop_cnt, o_m1_drop_cnt;

    always #5 clk = ~clk;

    tlk2711_reg_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_m0_wen(i_m0_wen), .i_m0_waddr(i_m0_waddr), .i_m0_wdata(i_m0_wdata),
        .i_m0_ren(i_m0_ren), .i_m0_raddr(i_m0_raddr),
        .o_m0_rdata(o_m0_rdata), .o_m0_rvalid(o_m0_rvalid), .o_m0_ovf(o_m0_ovf),
        .i_m1_wen(i_m1_wen), .i_m1_waddr(i_m1_waddr), .i_m1_wdata(i_m1_wdata),
        .i_m1_ren(i_m1_ren), .i_m1_raddr(i_m1_raddr),
        .o_m1_rdata(o_m1_rdata), .o_m1_rvalid(o_m1_rvalid), .o_m1_ovf(o_m1_ovf),
        .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
        .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata),
        .o_busy(o_busy), .o_m0_drop_cnt(o_m0_drop_cnt), .o_m1_drop_cnt(o_m1_drop_cnt)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];
    exp_t rv0_q[$];
    exp_t rv1_q[$];
    exp_t ovf0_q[$];
    exp_t ovf1_q[$];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = {a, 16'hC0DE, a, ~a};
        if (a == 16'h0020) v = 64'h55;
        return v;
    endfunction

    // Register file stand-in: data is valid only in cycle T+RD_LAT after a read strobe at T.
    logic [RD_LAT:0] pipe = '0;
    always @(negedge clk) begin
        pipe        = {pipe[RD_LAT-1:0], o_reg_ren};
        i_reg_rdata = pipe[RD_LAT] ? rd_model(o_reg_raddr) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic cmp(input string name, input bit have, input exp_t e,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL %s unexpected at cycle %0d: addr=%h data=%h, required no event", name, cyc, a, d);
        end else if (e.cyc != cyc || e.addr !== a || e.data !== d) begin
            failures++;
            $display("FAIL %s: got cycle=%0d addr=%h data=%h, required cycle=%0d addr=%h data=%h",
                     name, cyc, a, d, e.cyc, e.addr, e.data);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   h;
        e = '{cyc: 0, addr: '0, data: '0};
        if (o_reg_wen) begin
            h = (wr_q.size() > 0);
            if (h) e = wr_q.pop_front();
            cmp("reg_wr", h, e, o_reg_waddr, o_reg_wdata);
        end
        if (o_reg_ren) begin
            h = (rd_q.size() > 0);
            if (h) e = rd_q.pop_front();
            cmp("reg_rd", h, e, o_reg_raddr, '0);
        end
        if (o_m0_rvalid) begin
            h = (rv0_q.size() > 0);
            if (h) e = rv0_q.pop_front();
            cmp("m0_rvalid", h, e, '0, o_m0_rdata);
        end
        if (o_m1_rvalid) begin
            h = (rv1_q.size() > 0);
            if (h) e = rv1_q.pop_front();
            cmp("m1_rvalid", h, e, '0, o_m1_rdata);
        end
        if (o_m0_ovf) begin
            h = (ovf0_q.size() > 0);
            if (h) e = ovf0_q.pop_front();
            cmp("m0_ovf", h, e, '0, '0);
        end
        if (o_m1_ovf) begin
            h = (ovf1_q.size() > 0);
            if (h) e = ovf1_q.pop_front();
            cmp("m1_ovf", h, e, '0, '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i_m0_wen = 0; i_m0_ren = 0; i_m1_wen = 0; i_m1_ren = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 128'({o_reg_wen, o_reg_ren, o_reg_waddr, o_reg_raddr, o_busy,
                                  o_m0_rvalid, o_m1_rvalid, o_m0_ovf, o_m1_ovf,
                                  o_m0_drop_cnt, o_m1_drop_cnt}), '0);
        chk({tag, "_wdata"}, 128'(o_reg_wdata), '0);
        chk({tag, "_m0_rdata"}, 128'(o_m0_rdata), '0);
        chk({tag, "_m1_rdata"}, 128'(o_m1_rdata), '0);
    endtask

    int        c;
    logic [15:0] exp_drop;

    initial begin
        rst = 1;
        clr();
        i_m0_waddr = '0; i_m0_wdata = '0; i_m0_raddr = '0;
        i_m1_waddr = '0; i_m1_wdata = '0; i_m1_raddr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_all_zero("reset");
        step();

        // Single m0 write: issued two cycles after the strobe, no read data.
        c = cyc;
        i_m0_wen = 1; i_m0_waddr = 16'h0010; i_m0_wdata = 64'hDEADBEEF_00000001;
        wr_q.push_back('{c + 2, 16'h0010, 64'hDEADBEEF_00000001});
        step(); clr();
        repeat (6) step();

        // Single m1 read with RD_LAT=2.
        c = cyc;
        i_m1_ren = 1; i_m1_raddr = 16'h0020;
        rd_q.push_back('{c + 2, 16'h0020, '0});
        rv1_q.push_back('{c + 5, '0, 64'h55});
        step(); clr();
        step(); step();
        @(negedge clk);
        chk("busy_in_rd_wait", 128'(o_busy), 128'(1));
        repeat (6) step();
        chk("m1_rdata_held", 128'(o_m1_rdata), 128'(64'h55));
        chk("idle_not_busy", 128'(o_busy), 128'(0));

        // Simultaneous writes: m0 first, then a repeat with m1 first.
        c = cyc;
        i_m0_wen = 1; i_m0_waddr = 16'h0030; i_m0_wdata = 64'hA0A0_0000_0000_0030;
        i_m1_wen = 1; i_m1_waddr = 16'h0031; i_m1_wdata = 64'hB1B1_0000_0000_0031;
        wr_q.push_back('{c + 2, 16'h0030, 64'hA0A0_0000_0000_0030});
        wr_q.push_back('{c + 4, 16'h0031, 64'hB1B1_0000_0000_0031});
        step(); clr();
        repeat (6) step();
        c = cyc;
        i_m0_wen = 1; i_m0_waddr = 16'h0032; i_m0_wdata = 64'hA0A0_0000_0000_0032;
        i_m1_wen = 1; i_m1_waddr = 16'h0033; i_m1_wdata = 64'hB1B1_0000_0000_0033;
        wr_q.push_back('{c + 2, 16'h0033, 64'hB1B1_0000_0000_0033});
        wr_q.push_back('{c + 4, 16'h0032, 64'hA0A0_0000_0000_0032});
        step(); clr();
        repeat (6) step();

        // Three m0 writes around an m1 read; the one arriving in RD_WAIT finds the slot full.
        c = cyc;
        i_m0_wen = 1; i_m0_waddr = 16'h0070; i_m0_wdata = 64'h1111_0000_0000_0070;
        i_m1_ren = 1; i_m1_raddr = 16'h0040;
        wr_q.push_back('{c + 2, 16'h0070, 64'h1111_0000_0000_0070});
        rd_q.push_back('{c + 4, 16'h0040, '0});
        rv1_q.push_back('{c + 7, '0, rd_model(16'h0040)});
        wr_q.push_back('{c + 8, 16'h0071, 64'h2222_0000_0000_0071});
        ovf0_q.push_back('{c + 6, '0, '0});
        step(); clr();
        step();
        i_m0_wen = 1; i_m0_waddr = 16'h0071; i_m0_wdata = 64'h2222_0000_0000_0071;
        step(); clr();
        step(); step();
        i_m0_wen = 1; i_m0_waddr = 16'h0072; i_m0_wdata = 64'h3333_0000_0000_0072;
        step(); clr();
        repeat (8) step();
`ifdef TLK2711_REG_ARB_STATS_EN
        exp_drop = 16'd1;
`else
        exp_drop = 16'd0;
`endif
        chk("m0_drop_cnt", 128'(o_m0_drop_cnt), 128'(exp_drop));
        chk("m1_drop_cnt", 128'(o_m1_drop_cnt), 128'(0));

        // m0 write and read together: write slot wins.
        c = cyc;
        i_m0_wen = 1; i_m0_waddr = 16'h0050; i_m0_wdata = 64'h5050_5050_5050_5050;
        i_m0_ren = 1; i_m0_raddr = 16'h0051;
        wr_q.push_back('{c + 2, 16'h0050, 64'h5050_5050_5050_5050});
        rd_q.push_back('{c + 4, 16'h0051, '0});
        rv0_q.push_back('{c + 7, '0, rd_model(16'h0051)});
        step(); clr();
        repeat (9) step();

        // Reset in RD_WAIT drops the read and ignores the strobes in the reset cycle.
        c = cyc;
        i_m0_ren = 1; i_m0_raddr = 16'h0060;
        rd_q.push_back('{c + 2, 16'h0060, '0});
        step(); clr();
        repeat (3) step();
        rst = 1;
        i_m1_wen = 1; i_m1_waddr = 16'h0099; i_m1_wdata = 64'h9999;
        i_m0_ren = 1; i_m0_raddr = 16'h0062;
        step();
        rst = 0; clr();
        @(negedge clk);
        chk_all_zero("rd_wait_reset");
        step();
        c = cyc;
        i_m0_ren = 1; i_m0_raddr = 16'h0061;
        rd_q.push_back('{c + 2, 16'h0061, '0});
        rv0_q.push_back('{c + 5, '0, rd_model(16'h0061)});
        step(); clr();
        repeat (10) step();

        chk("pending_reg_wr", 128'(wr_q.size()), 128'(0));
        chk("pending_reg_rd", 128'(rd_q.size()), 128'(0));
        chk("pending_m0_rvalid", 128'(rv0_q.size()), 128'(0));
        chk("pending_m1_rvalid", 128'(rv1_q.size()), 128'(0));
        chk("pending_m0_ovf", 128'(ovf0_q.size()), 128'(0));
        chk("pending_m1_ovf", 128'(ovf1_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlk2711_reg_arb.md
TLK2711_REG_ARB -- requirements
Module: tlk2711_reg_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-003 SHALL have parameter RD_LAT, default 2, range 1..7: cycles from o_reg_ren to valid i_reg_rdata.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports i_mN_wen, input, 1, requester N write strobe (N = 0 PS, N = 1 VIO debug; same set for each N).
REQ-007 SHALL have ports i_mN_waddr and i_mN_wdata, inputs, ADDR_WIDTH and DATA_WIDTH, write address and data.
REQ-008 SHALL have ports i_mN_ren and i_mN_raddr, inputs, 1 and ADDR_WIDTH, read strobe and address.
REQ-009 SHALL have ports o_mN_rdata and o_mN_rvalid, outputs, DATA_WIDTH and 1, routed read data and its one-cycle valid.
REQ-010 SHALL have port o_mN_ovf, output, 1, one-cycle pulse when a request from N is dropped.
REQ-011 SHALL have ports o_reg_wen, o_reg_waddr and o_reg_wdata, outputs, write strobe, address and data to tlk2711_top.
REQ-012 SHALL have ports o_reg_ren and o_reg_raddr, outputs, read strobe and address to tlk2711_top.
REQ-013 SHALL have port i_reg_rdata, input, DATA_WIDTH, read data from tlk2711_top.
REQ-014 SHALL have port o_busy, output, 1, high while the FSM is not IDLE.
REQ-015 SHALL have ports o_m0_drop_cnt and o_m1_drop_cnt, outputs, 16 bits each, dropped-request counters.

Function
REQ-016 SHALL give each requester one write slot and one read slot, each capturing address (and data for writes) on its strobe.
REQ-017 SHALL, when a strobe arrives while its slot is full and the slot is not being issued that cycle, drop the new request, keep the old one and pulse o_mN_ovf.
REQ-018 SHALL, when a slot is issued in the same cycle a new strobe arrives, accept the new request into that slot.
REQ-019 SHALL run FSM states IDLE, ISSUE and RD_WAIT.
REQ-020 SHALL, in IDLE with any slot full, select a slot and enter ISSUE on the next cycle.
REQ-021 SHALL select requesters round-robin, granting the requester not granted last when both are pending; within one requester the write slot wins over the read slot.
REQ-022 SHALL, in ISSUE, drive o_reg_wen or o_reg_ren high for exactly one cycle and free the slot in that cycle.
REQ-023 SHALL return from ISSUE to IDLE after a write.
REQ-024 SHALL enter RD_WAIT from ISSUE after a read.
REQ-025 SHALL, for a read strobe at cycle T, sample i_reg_rdata at T+RD_LAT, present it on o_mN_rdata of the owning requester, pulse o_mN_rvalid at T+RD_LAT+1, and return to IDLE that same cycle.
REQ-026 SHALL hold o_reg_* address and data stable except in ISSUE, and keep strobes low outside ISSUE.
REQ-027 SHALL allow at most one register operation in flight; a new grant is never made during RD_WAIT.
REQ-028 SHALL keep o_mN_rdata at its last value between valid pulses.

Reset
REQ-029 SHALL, on rst, clear all slots, enter IDLE, set the round-robin pointer to "last = m1" so that m0 is granted first, and drive every output to 0.
REQ-030 SHALL, on rst during RD_WAIT, discard the in-flight read with no rvalid pulse, and ignore strobes present in the reset cycle.

Configuration
REQ-031 SHALL, with TLK2711_REG_ARB_STATS_EN defined, increment o_mN_drop_cnt on each o_mN_ovf pulse, saturating at 0xFFFF and cleared by rst.
REQ-032 SHALL, without TLK2711_REG_ARB_STATS_EN, keep the drop counter ports present and tied to 0; all other behaviour is identical.

Structure
REQ-033 SHALL place the FSM state enum, the slot-kind type (WR/RD), the default widths and the counter width in shared package tlk2711_reg_pkg.
REQ-034 SHALL implement the per-requester write/read slot pair as sub-module tlk2711_reg_slot, instantiated twice.

Verification
REQ-035 SHALL cover: m0 write addr 0x0010 data 0xDEADBEEF_00000001 -> o_reg_wen pulses 2 cycles later with the same addr/data; no rvalid.
REQ-036 SHALL cover: RD_LAT=2, m1 read 0x0020 with i_reg_rdata=0x55 at T+2 -> o_m1_rvalid at T+3 with 0x55; o_m0_rvalid stays 0.
REQ-037 SHALL cover: m0 and m1 write in the same cycle -> m0 issued first, m1 next; a repeat of both -> m1 first, then m0.
REQ-038 SHALL cover: m0 three back-to-back writes while m1 holds a read in RD_WAIT -> third write dropped, o_m0_ovf pulse, drop_cnt=1 (macro on) / 0 (macro off).
REQ-039 SHALL cover: m0 write and read strobes in the same cycle -> write issued before read; rvalid follows.
REQ-040 SHALL cover: rst asserted one cycle into RD_WAIT -> no rvalid, all outputs 0, next m0 read completes normally.
